// File: rtl/peak_result_streamer_pkg.sv
// Shared types and defaults for the peak result streamer.
// Defaults match the histogram/peak detector geometry.
package peak_result_streamer_pkg;

    localparam int NP_DEF        = 8;
    localparam int PIXEL_NUM_DEF = 4;
    localparam int FID_W_DEF     = 8;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } state_t;

    function automatic int pix_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/peak_result_streamer_if.sv
// Per-pixel result beat stream with valid/ready handshake.
// Master drives the beat fields, slave drives ready.
interface peak_result_streamer_if
    import peak_result_streamer_pkg::*;
#(
    parameter int NP    = NP_DEF,
    parameter int PIX_W = pix_w(PIXEL_NUM_DEF),
    parameter int FID_W = FID_W_DEF
);

    logic             valid;
    logic             ready;
    logic [PIX_W-1:0] pixel;
    logic [NP-1:0]    tof;
    logic             nohit;
    logic             sof;
    logic             eof;
    logic [FID_W-1:0] frame_id;

    modport master (
        output valid,
        output pixel,
        output tof,
        output nohit,
        output sof,
        output eof,
        output frame_id,
        input  ready
    );

    modport slave (
        input  valid,
        input  pixel,
        input  tof,
        input  nohit,
        input  sof,
        input  eof,
        input  frame_id,
        output ready
    );

endinterface

// File: rtl/peak_result_streamer.sv
// Captures the packed peak vector per frame and streams it one
// pixel per beat; one active and one pending frame, overruns dropped.
module peak_result_streamer
    import peak_result_streamer_pkg::*;
#(
    parameter int NP        = NP_DEF,
    parameter int PIXEL_NUM = PIXEL_NUM_DEF,
    parameter int FID_W     = FID_W_DEF,
    parameter int PIX_W     = pix_w(PIXEL_NUM)
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    frame_done,
    input  logic [NP*PIXEL_NUM-1:0] result,
    peak_result_streamer_if.master  m,
    output logic                    busy,
    output logic                    overrun,
    output logic [FID_W-1:0]        drop_cnt
);

    localparam int               RW   = NP * PIXEL_NUM;
    localparam logic [PIX_W-1:0] LAST = PIX_W'(PIXEL_NUM - 1);

    state_t           state;
    state_t           state_nxt;
    logic [RW-1:0]    act_buf;
    logic [RW-1:0]    pend_buf;
    logic             pend_full;
    logic [PIX_W-1:0] idx;
    logic [FID_W-1:0] fid_cnt;
    logic [FID_W-1:0] cur_fid;
    logic [NP-1:0]    tof_sel;

    logic streaming;
    logic xfer;
    logic last_xfer;
    logic load_act;
    logic act_from_pend;
    logic pend_load;
    logic pend_clear;
    logic drop;

    assign streaming = (state == ST_STREAM);
    assign xfer      = streaming && m.ready;
    assign last_xfer = xfer && (idx == LAST);

    always_ff @(posedge clk) begin
        if (res) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (frame_done) begin
                    state_nxt = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (last_xfer && !pend_full && !frame_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A last-beat transfer frees the active slot in the same edge,
    // so a coincident frame_done is never counted as an overrun.
    always_comb begin
        act_from_pend = last_xfer && pend_full;
        load_act      = (!streaming && frame_done)
                      || (last_xfer && (pend_full || frame_done));
        pend_load     = streaming && frame_done
                      && ((last_xfer && pend_full)
                          || (!last_xfer && !pend_full));
        pend_clear    = last_xfer && pend_full && !frame_done;
        drop          = streaming && frame_done
                      && !last_xfer && pend_full;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            act_buf   <= '0;
            pend_buf  <= '0;
            pend_full <= 1'b0;
            idx       <= '0;
            fid_cnt   <= '0;
            cur_fid   <= '0;
            overrun   <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (load_act) begin
                act_buf <= act_from_pend ? pend_buf : result;
                idx     <= '0;
                cur_fid <= fid_cnt;
                fid_cnt <= fid_cnt + FID_W'(1);
            end else if (xfer) begin
                idx <= (idx == LAST) ? '0 : idx + PIX_W'(1);
            end

            if (pend_load) begin
                pend_buf  <= result;
                pend_full <= 1'b1;
            end else if (pend_clear) begin
                pend_full <= 1'b0;
            end

            if (drop) begin
                overrun <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + FID_W'(1);
                end
            end
        end
    end

    assign tof_sel = act_buf[int'(idx)*NP +: NP];

    // Beat fields are forced to zero when idle so reset clears every output.
    always_comb begin
        m.valid    = streaming;
        busy       = streaming;
        m.pixel    = '0;
        m.tof      = '0;
        m.nohit    = 1'b0;
        m.sof      = 1'b0;
        m.eof      = 1'b0;
        m.frame_id = '0;
        if (streaming) begin
            m.pixel    = idx;
            m.tof      = tof_sel;
            m.nohit    = (tof_sel == '0);
            m.sof      = (idx == '0);
            m.eof      = (idx == LAST);
            m.frame_id = cur_fid;
        end
    end

endmodule

// File: tb/tb_peak_result_streamer.sv
// Directed bench for peak_result_streamer: vector table for the
// basic stream/stall/nohit cases plus hand sequences for corner cases.
module tb_peak_result_streamer;

    localparam int NP    = 8;
    localparam int PN    = 4;
    localparam int FID_W = 8;
    localparam int PIX_W = 2;

    logic              clk;
    logic              res;
    logic              frame_done;
    logic [NP*PN-1:0]  result;
    logic              busy;
    logic              overrun;
    logic [FID_W-1:0]  drop_cnt;

    int n_chk;
    int n_fail;

    peak_result_streamer_if #(
        .NP(NP), .PIX_W(PIX_W), .FID_W(FID_W)
    ) m_if ();

    peak_result_streamer #(
        .NP(NP), .PIXEL_NUM(PN), .FID_W(FID_W)
    ) dut (
        .clk        (clk),
        .res        (res),
        .frame_done (frame_done),
        .result     (result),
        .m          (m_if),
        .busy       (busy),
        .overrun    (overrun),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fd;
        logic [31:0] res_v;
        logic        rdy;
        logic        ev;
        int          epix;
        logic [7:0]  etof;
        logic        enh;
        logic        esof;
        logic        eeof;
        logic [7:0]  efid;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(
        input logic fd, input logic [31:0] r, input logic rdy,
        input logic ev, input int p, input logic [7:0] t,
        input logic nh, input logic [7:0] fid
    );
        vec_t v;
        v.fd    = fd;
        v.res_v = r;
        v.rdy   = rdy;
        v.ev    = ev;
        v.epix  = ev ? p : 0;
        v.etof  = ev ? t : 8'h00;
        v.enh   = ev && nh;
        v.esof  = ev && (p == 0);
        v.eeof  = ev && (p == PN - 1);
        v.efid  = ev ? fid : 8'h00;
        return v;
    endfunction

    function automatic void chk(
        input string name, input logic [31:0] act, input logic [31:0] exp
    );
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(
        input string tag, input logic v, input int p, input logic [7:0] t,
        input logic nh, input logic [7:0] fid
    );
        chk({tag, ".valid"}, 32'(m_if.valid), 32'(v));
        chk({tag, ".busy"}, 32'(busy), 32'(v));
        chk({tag, ".pixel"}, 32'(m_if.pixel), v ? 32'(p) : 32'd0);
        chk({tag, ".tof"}, 32'(m_if.tof), v ? 32'(t) : 32'd0);
        chk({tag, ".nohit"}, 32'(m_if.nohit), 32'(v && nh));
        chk({tag, ".sof"}, 32'(m_if.sof), 32'(v && p == 0));
        chk({tag, ".eof"}, 32'(m_if.eof), 32'(v && p == PN - 1));
        chk({tag, ".fid"}, 32'(m_if.frame_id), v ? 32'(fid) : 32'd0);
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        res        = 1'b1;
        frame_done = 1'b0;
        result     = '0;
        m_if.ready = 1'b0;

        vecs[0]  = mk(1, 32'h04030201, 1, 1, 0, 8'h01, 0, 0);
        vecs[1]  = mk(0, 32'h0, 1, 1, 1, 8'h02, 0, 0);
        vecs[2]  = mk(0, 32'h0, 1, 1, 2, 8'h03, 0, 0);
        vecs[3]  = mk(0, 32'h0, 1, 1, 3, 8'h04, 0, 0);
        vecs[4]  = mk(0, 32'h0, 1, 0, 0, 8'h00, 0, 0);
        vecs[5]  = mk(1, 32'h14131211, 0, 1, 0, 8'h11, 0, 1);
        vecs[6]  = mk(0, 32'h0, 0, 1, 0, 8'h11, 0, 1);
        vecs[7]  = mk(0, 32'h0, 0, 1, 0, 8'h11, 0, 1);
        vecs[8]  = mk(0, 32'h0, 1, 1, 1, 8'h12, 0, 1);
        vecs[9]  = mk(0, 32'h0, 0, 1, 1, 8'h12, 0, 1);
        vecs[10] = mk(0, 32'h0, 1, 1, 2, 8'h13, 0, 1);
        vecs[11] = mk(0, 32'h0, 1, 1, 3, 8'h14, 0, 1);
        vecs[12] = mk(0, 32'h0, 0, 1, 3, 8'h14, 0, 1);
        vecs[13] = mk(0, 32'h0, 1, 0, 0, 8'h00, 0, 0);
        vecs[14] = mk(1, 32'h44004241, 1, 1, 0, 8'h41, 0, 2);
        vecs[15] = mk(0, 32'h0, 1, 1, 1, 8'h42, 0, 2);
        vecs[16] = mk(0, 32'h0, 1, 1, 2, 8'h00, 1, 2);
        vecs[17] = mk(0, 32'h0, 1, 1, 3, 8'h44, 0, 2);
        vecs[18] = mk(0, 32'h0, 1, 0, 0, 8'h00, 0, 0);

        step();
        step();
        chk_beat("reset", 0, 0, 8'h00, 0, 8'h00);
        chk("reset.overrun", 32'(overrun), 32'd0);
        chk("reset.drop_cnt", 32'(drop_cnt), 32'd0);
        res = 1'b0;

        for (int i = 0; i < 19; i++) begin
            frame_done = vecs[i].fd;
            result     = vecs[i].res_v;
            m_if.ready = vecs[i].rdy;
            step();
            frame_done = 1'b0;
            chk_beat($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epix,
                     vecs[i].etof, vecs[i].enh, vecs[i].efid);
        end
        chk("tbl.overrun", 32'(overrun), 32'd0);

        // frame_done coincident with eof transfer, pending empty
        m_if.ready = 1'b1;
        frame_done = 1'b1;
        result     = 32'h24232221;
        step();
        frame_done = 1'b0;
        chk_beat("c4.a0", 1, 0, 8'h21, 0, 8'd3);
        for (int p = 1; p < PN; p++) begin
            step();
            chk_beat($sformatf("c4.a%0d", p), 1, p, 8'(8'h21 + p), 0, 8'd3);
        end
        frame_done = 1'b1;
        result     = 32'h34333231;
        step();
        frame_done = 1'b0;
        chk_beat("c4.b0", 1, 0, 8'h31, 0, 8'd4);
        for (int p = 1; p < PN; p++) begin
            step();
            chk_beat($sformatf("c4.b%0d", p), 1, p, 8'(8'h31 + p), 0, 8'd4);
        end
        step();
        chk_beat("c4.idle", 0, 0, 8'h00, 0, 8'h00);

        // stalled sink: B pending, C dropped, then coincident D at A eof
        m_if.ready = 1'b0;
        frame_done = 1'b1;
        result     = 32'h54535251;
        step();
        chk_beat("c3.a0", 1, 0, 8'h51, 0, 8'd5);
        result = 32'h64636261;
        step();
        chk_beat("c3.bpend", 1, 0, 8'h51, 0, 8'd5);
        chk("c3.bpend.drop", 32'(drop_cnt), 32'd0);
        chk("c3.bpend.ovr", 32'(overrun), 32'd0);
        result = 32'h74737271;
        step();
        frame_done = 1'b0;
        chk_beat("c3.cdrop", 1, 0, 8'h51, 0, 8'd5);
        chk("c3.cdrop.drop", 32'(drop_cnt), 32'd1);
        chk("c3.cdrop.ovr", 32'(overrun), 32'd1);
        m_if.ready = 1'b1;
        for (int p = 1; p < PN; p++) begin
            step();
            chk_beat($sformatf("c3.a%0d", p), 1, p, 8'(8'h51 + p), 0, 8'd5);
        end
        frame_done = 1'b1;
        result     = 32'h84838281;
        step();
        frame_done = 1'b0;
        chk_beat("c3.b0", 1, 0, 8'h61, 0, 8'd6);
        chk("c3.b0.drop", 32'(drop_cnt), 32'd1);
        for (int p = 1; p < PN; p++) begin
            step();
            chk_beat($sformatf("c3.b%0d", p), 1, p, 8'(8'h61 + p), 0, 8'd6);
        end
        step();
        chk_beat("c3.d0", 1, 0, 8'h81, 0, 8'd7);
        for (int p = 1; p < PN; p++) begin
            step();
            chk_beat($sformatf("c3.d%0d", p), 1, p, 8'(8'h81 + p), 0, 8'd7);
        end
        step();
        chk_beat("c3.idle", 0, 0, 8'h00, 0, 8'h00);
        chk("c3.end.drop", 32'(drop_cnt), 32'd1);
        chk("c3.end.ovr", 32'(overrun), 32'd1);

        // reset in the middle of a frame
        frame_done = 1'b1;
        result     = 32'h94939291;
        step();
        frame_done = 1'b0;
        chk_beat("c6.e0", 1, 0, 8'h91, 0, 8'd8);
        step();
        chk_beat("c6.e1", 1, 1, 8'h92, 0, 8'd8);
        res = 1'b1;
        step();
        res = 1'b0;
        chk_beat("c6.rst", 0, 0, 8'h00, 0, 8'h00);
        chk("c6.rst.ovr", 32'(overrun), 32'd0);
        chk("c6.rst.drop", 32'(drop_cnt), 32'd0);
        frame_done = 1'b1;
        result     = 32'hA4A3A2A1;
        step();
        frame_done = 1'b0;
        chk_beat("c6.f0", 1, 0, 8'hA1, 0, 8'd0);
        for (int p = 1; p < PN; p++) begin
            step();
            chk_beat($sformatf("c6.f%0d", p), 1, p, 8'(8'hA1 + p), 0, 8'd0);
        end
        step();
        chk_beat("c6.idle", 0, 0, 8'h00, 0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
